mem_access_unit: RTL and testbench

Parametrised pipeline memory stage for the superscalar core, replacing the single-cycle MEM stage. It owns a private data RAM and executes byte, halfword, word and (when D_WIDTH=64) doubleword loads and stores with sign or zero extension. Access latency is configurable, with a stall handshake back to EX, and all results are registered into the WB boundary. Non-memory instructions pass through in one cycle.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Pipelined MEM stage with a private byte-enable data RAM, sign/zero-extended loads,
// configurable access latency and a stall handshake back to EX.
module mem_access_unit #(
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 256,
    parameter int LAT     = 2,
    parameter int REG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic               i_flush,
    input  logic               i_PCSrcM,
    input  logic               i_RegWriteM,
    input  logic               i_MemtoRegM,
    input  logic               i_MemWriteM,
    input  logic [1:0]         i_Size,
    input  logic               i_Unsigned,
    input  logic [D_WIDTH-1:0] i_ALUResultM,
    input  logic [D_WIDTH-1:0] i_WriteDataM,
    input  logic [REG_W-1:0]   i_WA3M,
    output logic               o_stall,
    output logic               o_valid,
    output logic               o_PCSrcW,
    output logic               o_RegWriteW,
    output logic               o_MemtoRegW,
    output logic [D_WIDTH-1:0] o_RD,
    output logic [D_WIDTH-1:0] o_ALUOutW,
    output logic [REG_W-1:0]   o_WA3W,
    output logic               o_misalign
);
    localparam int NB = D_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_n;
    logic [2:0]         cnt, cnt_n;
    logic [D_WIDTH-1:0] mem [DEPTH];

    logic [OB-1:0]      off, amask;
    logic [AW-1:0]      idx;
    logic [NB-1:0]      lmask, be;
    logic [D_WIDTH-1:0] wsh, rsh, keep, ld_data;
    logic               sbit, mem_op, illegal, misalign, legal, is_store, retire, ram_we;

    assign off      = i_ALUResultM[OB-1:0];
    assign idx      = i_ALUResultM[OB+AW-1:OB];
    assign mem_op   = i_valid & (i_MemtoRegM | i_MemWriteM);
    assign is_store = i_MemWriteM & ~i_MemtoRegM;
    assign illegal  = (i_Size == 2'b11) && (D_WIDTH == 32);

    // Per-size lane mask, alignment mask, load keep-mask and sign bit position
    always_comb begin
        lmask = '1;
        amask = '1;
        keep  = '1;
        sbit  = rsh[D_WIDTH-1];
        case (i_Size)
            2'b00: begin lmask = NB'(1);  amask = '0;     keep = D_WIDTH'(32'hFF);        sbit = rsh[7];  end
            2'b01: begin lmask = NB'(3);  amask = OB'(1); keep = D_WIDTH'(32'hFFFF);      sbit = rsh[15]; end
            2'b10: begin lmask = NB'(15); amask = OB'(3); keep = D_WIDTH'(32'hFFFF_FFFF); sbit = rsh[31]; end
            default: ;
        endcase
    end

    assign misalign = mem_op & (illegal | (|(off & amask)));
    assign legal    = mem_op & ~misalign;
    assign be       = lmask << off;
    assign wsh      = i_WriteDataM << {off, 3'b000};
    assign rsh      = mem[idx] >> {off, 3'b000};
    assign ld_data  = (i_Unsigned | ~sbit) ? (rsh & keep) : (rsh | ~keep);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (legal && (LAT > 1)) begin
                state_n = BUSY;
                cnt_n   = 3'd1;
            end
            BUSY: if (cnt == 3'(LAT - 1)) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 3'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        retire  = 1'b0;
        case (state)
            IDLE: begin
                o_stall = legal && (LAT > 1);
                retire  = i_valid && !(legal && (LAT > 1));
            end
            BUSY: begin
                o_stall = cnt < 3'(LAT - 1);
                retire  = cnt == 3'(LAT - 1);
            end
            default: ;
        endcase
    end

    // Write lands on the retiring edge, so a following load sees it without a bypass
    assign ram_we = retire & legal & is_store & ~i_flush & ~rst;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (ram_we && be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid     <= 1'b0;
            o_PCSrcW    <= 1'b0;
            o_RegWriteW <= 1'b0;
            o_MemtoRegW <= 1'b0;
            o_RD        <= '0;
            o_ALUOutW   <= '0;
            o_WA3W      <= '0;
            o_misalign  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= retire;
            if (retire) begin
                o_PCSrcW    <= i_PCSrcM;
                o_RegWriteW <= i_RegWriteM & ~misalign;
                o_MemtoRegW <= i_MemtoRegM;
                o_RD        <= (legal & i_MemtoRegM) ? ld_data : '0;
                o_ALUOutW   <= i_ALUResultM;
                o_WA3W      <= i_WA3M;
                o_misalign  <= misalign;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (D_WIDTH=32, DEPTH=256, LAT=2): directed plan plus random ops
// checked against a byte-array memory model.
module tb_mem_access_unit;
    localparam int DW = 32, DEPTH = 256, LAT = 2, RW = 4;
    localparam int NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, i_valid, i_flush, i_PCSrcM, i_RegWriteM, i_MemtoRegM, i_MemWriteM, i_Unsigned;
    logic [1:0] i_Size;
    logic [DW-1:0] i_ALUResultM, i_WriteDataM;
    logic [RW-1:0] i_WA3M;
    logic o_stall, o_valid, o_PCSrcW, o_RegWriteW, o_MemtoRegW, o_misalign;
    logic [DW-1:0] o_RD, o_ALUOutW;
    logic [RW-1:0] o_WA3W;

    mem_access_unit #(.D_WIDTH(DW), .DEPTH(DEPTH), .LAT(LAT), .REG_W(RW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_PCSrcM(i_PCSrcM), .i_RegWriteM(i_RegWriteM), .i_MemtoRegM(i_MemtoRegM),
        .i_MemWriteM(i_MemWriteM), .i_Size(i_Size), .i_Unsigned(i_Unsigned),
        .i_ALUResultM(i_ALUResultM), .i_WriteDataM(i_WriteDataM), .i_WA3M(i_WA3M),
        .o_stall(o_stall), .o_valid(o_valid), .o_PCSrcW(o_PCSrcW), .o_RegWriteW(o_RegWriteW),
        .o_MemtoRegW(o_MemtoRegW), .o_RD(o_RD), .o_ALUOutW(o_ALUOutW), .o_WA3W(o_WA3W),
        .o_misalign(o_misalign)
    );

    int tests = 0, fails = 0;
    logic [7:0] mb [NBYTES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a, input int sz, input bit uns);
        int n = 1 << sz;
        int base = int'(a % NBYTES);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_rd"}, o_RD, 0);
        chk({tag, "_alu"}, o_ALUOutW, 0);
        chk({tag, "_wa3"}, o_WA3W, 0);
        chk({tag, "_ctrl"}, {o_PCSrcW, o_RegWriteW, o_MemtoRegW, o_misalign}, 0);
    endtask

    // Presents one op, checks the stall profile and the retired result against the model
    task automatic run_op(input bit vld, input bit ld, input bit st, input bit rw, input bit pcs,
                          input logic [1:0] sz, input bit uns, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wa);
        bit memop = vld && (ld || st);
        int n = 1 << sz;
        bit mis = memop && (sz == 2'b11 || (a % n) != 0);
        int lat = (memop && !mis) ? LAT : 1;
        logic [31:0] erd = (vld && ld && !mis) ? mread(a, int'(sz), uns) : 32'd0;
        if (memop && !mis && !ld)
            for (int i = 0; i < n; i++) mb[int'(a % NBYTES) + i] = wd[8*i +: 8];
        i_valid = vld; i_MemtoRegM = ld; i_MemWriteM = st; i_RegWriteM = rw; i_PCSrcM = pcs;
        i_Size = sz; i_Unsigned = uns; i_ALUResultM = a; i_WriteDataM = wd; i_WA3M = wa;
        #1;
        for (int k = 0; k < lat; k++) begin
            chk("stall", o_stall, (k < lat - 1) ? 1 : 0);
            if (k > 0) chk("valid_busy", o_valid, 0);
            @(posedge clk);
            #1;
        end
        chk("valid", o_valid, vld);
        if (vld) begin
            chk("rd", o_RD, erd);
            chk("aluout", o_ALUOutW, a);
            chk("wa3", o_WA3W, wa);
            chk("regwrite", o_RegWriteW, rw && !mis);
            chk("memtoreg", o_MemtoRegW, ld);
            chk("pcsrc", o_PCSrcW, pcs);
            chk("misalign", o_misalign, mis);
        end
    endtask

    initial begin
        logic [31:0] old20;
        rst = 1; i_valid = 0; i_flush = 0; i_PCSrcM = 0; i_RegWriteM = 0; i_MemtoRegM = 0;
        i_MemWriteM = 0; i_Size = 0; i_Unsigned = 0; i_ALUResultM = 0; i_WriteDataM = 0; i_WA3M = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        chk("reset_stall", o_stall, 0);
        rst = 0;

        // Fill RAM so every later load has a defined reference value
        for (int w = 0; w < DEPTH; w++) run_op(1, 0, 1, 0, 0, 2'b10, 0, w * 4, $urandom, 0);

        // Word store then load
        run_op(1, 0, 1, 0, 0, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h10, 0, 3);
        chk("lw_deadbeef", o_RD, 32'hDEAD_BEEF);

        // Byte store, signed/unsigned byte loads, then word view
        run_op(1, 0, 1, 0, 0, 2'b00, 0, 32'h13, 32'h80, 0);
        run_op(1, 1, 0, 1, 0, 2'b00, 0, 32'h13, 0, 4);
        chk("lb_sext", o_RD, 32'hFFFF_FF80);
        run_op(1, 1, 0, 1, 0, 2'b00, 1, 32'h13, 0, 4);
        chk("lbu_zext", o_RD, 32'h0000_0080);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h10, 0, 5);
        chk("lw_byte3", o_RD, 32'h80AD_BEEF);

        // Misaligned halfword load and misaligned word store
        run_op(1, 1, 0, 1, 0, 2'b01, 0, 32'h11, 0, 6);
        run_op(1, 0, 1, 0, 0, 2'b10, 0, 32'h12, 32'h1111_1111, 0);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h10, 0, 5);
        chk("ram_unchanged", o_RD, 32'h80AD_BEEF);

        // ALU op right after a load, then an illegal dword
        run_op(1, 1, 0, 1, 0, 2'b01, 0, 32'h10, 0, 2);
        run_op(1, 0, 0, 1, 1, 2'b10, 0, 32'h55, 32'h99, 7);
        run_op(1, 1, 0, 1, 0, 2'b11, 0, 32'h18, 0, 8);
        run_op(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Flush on the retiring edge of a store
        old20 = mread(32'h20, 2, 0);
        i_valid = 1; i_MemtoRegM = 0; i_MemWriteM = 1; i_RegWriteM = 0; i_Size = 2'b10;
        i_ALUResultM = 32'h20; i_WriteDataM = 32'h1234;
        #1;
        chk("flush_stall0", o_stall, 1);
        @(posedge clk); #1;
        chk("flush_stall1", o_stall, 0);
        i_flush = 1;
        @(posedge clk); #1;
        i_flush = 0; i_valid = 0;
        #1;
        chk("flush_valid", o_valid, 0);
        chk("flush_idle_stall", o_stall, 0);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h20, 0, 1);
        chk("flush_old", o_RD, old20);

        // Reset in BUSY aborts a store
        run_op(1, 0, 1, 0, 0, 2'b10, 0, 32'h40, 32'hCAFE_F00D, 0);
        run_op(1, 0, 0, 1, 1, 2'b00, 0, 32'h77, 0, 9);
        i_valid = 1; i_MemtoRegM = 0; i_MemWriteM = 1; i_Size = 2'b10;
        i_ALUResultM = 32'h40; i_WriteDataM = 32'h1111_1111;
        #1;
        chk("rst_busy_stall", o_stall, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; i_valid = 0;
        #1;
        chk_zero_outputs("rst_busy");
        chk("rst_busy_stall_after", o_stall, 0);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h40, 0, 1);
        chk("rst_keeps_ram", o_RD, 32'hCAFE_F00D);

        // Address wrap, and load+store together acts as a load
        run_op(1, 0, 1, 0, 0, 2'b10, 0, 32'h400, 32'h5A5A_1234, 0);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h000, 0, 2);
        chk("wrap", o_RD, 32'h5A5A_1234);
        run_op(1, 1, 1, 1, 0, 2'b10, 0, 32'h000, 32'hFFFF_FFFF, 2);
        run_op(1, 1, 0, 1, 0, 2'b10, 0, 32'h000, 0, 2);
        chk("ldst_no_write", o_RD, 32'h5A5A_1234);

        for (int r = 0; r < 200; r++) begin
            int t = int'($urandom_range(0, 4));
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom_range(0, 2047);
            if ($urandom_range(0, 9) < 8) a = a & ~((32'd1 << sz) - 32'd1);
            run_op(t != 4, t == 0 || t == 3, t == 1 || t == 3, 1'($urandom), 1'($urandom),
                   sz, 1'($urandom), a, $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
